// File: rtl/rssi_frontend_pkg.sv
// Shared constants for the RSSI front end: word format, anchor IDs and FSM encodings.
package rssi_frontend_pkg;

   localparam int RSSI_W    = 20;
   localparam int INT_BITS  = 8;
   localparam int FRAC_BITS = 12;

   localparam logic [1:0] ANCH_A       = 2'd0;
   localparam logic [1:0] ANCH_B       = 2'd1;
   localparam logic [1:0] ANCH_C       = 2'd2;
   localparam logic [1:0] ANCH_ILLEGAL = 2'd3;

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] DIVIDE  = 1'b1;

endpackage

// File: rtl/rssi_acc.sv
// One anchor's sample accumulator: sums 2^LOG2_N signed samples and exposes
// the floor average (arithmetic shift) of the window.
module rssi_acc
   import rssi_frontend_pkg::*;
#(
   parameter int W      = RSSI_W,
   parameter int LOG2_N = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                add_en,
   input  logic signed [W-1:0] sample,
   output logic                full,
   output logic                full_next,
   output logic signed [W-1:0] avg
);

   localparam int AW = W + LOG2_N;
   localparam int CW = LOG2_N + 1;
   localparam logic [CW-1:0] N_CNT = CW'(1 << LOG2_N);

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] shifted;
   logic        [CW-1:0] count;
   logic                 do_add;

   assign full      = (count == N_CNT);
   assign do_add    = add_en && !full;
   // Lets the FSM leave COLLECT on the same edge that the last sample lands.
   assign full_next = full || (do_add && (count == N_CNT - 1'b1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
      end else if (clear) begin
         acc   <= '0;
         count <= '0;
      end else if (do_add) begin
         acc   <= acc + {{LOG2_N{sample[W-1]}}, sample};
         count <= count + 1'b1;
      end
   end

   assign shifted = acc >>> LOG2_N;
   assign avg     = shifted[W-1:0];

endmodule

// File: rtl/rssi_frontend.sv
// Averages per-anchor RSSI windows and hands them to the solver only while it is idle.
module rssi_frontend
   import rssi_frontend_pkg::*;
#(
   parameter int LOG2_N = 2,
   parameter int W      = RSSI_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         sample_valid,
   input  logic [1:0]   anchor_id,
   input  logic [W-1:0] rssi_in,
   input  logic         busy,
   output logic [W-1:0] rssiA,
   output logic [W-1:0] rssiB,
   output logic [W-1:0] rssiC,
   output logic         rssi_ready,
   output logic         out_update,
   output logic         sample_drop,
   output logic         id_err,
   output logic         overrun
);

   logic [0:0]   state;
   logic         pend;
   logic [W-1:0] pending [3];
   logic [W-1:0] avg     [3];
   logic [2:0]   full;
   logic [2:0]   full_next;
   logic [2:0]   add_en;
   logic         valid_id;
   logic         anchor_full;
   logic         clear_acc;
   logic         transfer;
   logic         div_write;
   logic         drop;

   assign valid_id  = sample_valid && (anchor_id != ANCH_ILLEGAL);
   assign clear_acc = flush || (state == DIVIDE);
   assign transfer  = !flush && pend && !busy;
   assign div_write = !flush && (state == DIVIDE);

   always_comb begin
      anchor_full = 1'b0;
      case (anchor_id)
         ANCH_A:  anchor_full = full[0];
         ANCH_B:  anchor_full = full[1];
         ANCH_C:  anchor_full = full[2];
         default: anchor_full = 1'b0;
      endcase
   end

   // A flushed sample vanishes silently; otherwise DIVIDE or a full anchor drops it.
   assign drop = !flush && valid_id && ((state == DIVIDE) || anchor_full);

   for (genvar i = 0; i < 3; i++) begin : g_acc
      assign add_en[i] = !flush && (state == COLLECT) && valid_id && (anchor_id == 2'(i));

      rssi_acc #(
         .W      (W),
         .LOG2_N (LOG2_N)
      ) u_acc (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (clear_acc),
         .add_en    (add_en[i]),
         .sample    (rssi_in),
         .full      (full[i]),
         .full_next (full_next[i]),
         .avg       (avg[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else if (flush) begin
         state <= COLLECT;
      end else begin
         case (state)
            COLLECT: if (&full_next) state <= DIVIDE;
            default: state <= COLLECT;
         endcase
      end
   end

   // When DIVIDE and transfer coincide, outputs take the old pending set and pend stays up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         pending[0] <= '0;
         pending[1] <= '0;
         pending[2] <= '0;
         rssiA      <= '0;
         rssiB      <= '0;
         rssiC      <= '0;
         rssi_ready <= 1'b0;
      end else begin
         if (flush) begin
            pend <= 1'b0;
         end else if (div_write) begin
            pend       <= 1'b1;
            pending[0] <= avg[0];
            pending[1] <= avg[1];
            pending[2] <= avg[2];
         end else if (transfer) begin
            pend <= 1'b0;
         end
         if (transfer) begin
            rssiA      <= pending[0];
            rssiB      <= pending[1];
            rssiC      <= pending[2];
            rssi_ready <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_update  <= 1'b0;
         sample_drop <= 1'b0;
         id_err      <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         out_update  <= transfer;
         sample_drop <= drop;
         id_err      <= sample_valid && (anchor_id == ANCH_ILLEGAL);
         overrun     <= div_write && pend && !transfer;
      end
   end

endmodule

// File: tb/tb_rssi_frontend.sv
// Directed self-checking bench for rssi_frontend with hand-computed expectations.
module tb_rssi_frontend;

   localparam int W = 20;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic         sample_valid;
   logic [1:0]   anchor_id;
   logic [W-1:0] rssi_in;
   logic         busy;
   logic [W-1:0] rssiA;
   logic [W-1:0] rssiB;
   logic [W-1:0] rssiC;
   logic         rssi_ready;
   logic         out_update;
   logic         sample_drop;
   logic         id_err;
   logic         overrun;

   int tests;
   int failures;

   rssi_frontend #(
      .LOG2_N (2),
      .W      (W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .sample_valid (sample_valid),
      .anchor_id    (anchor_id),
      .rssi_in      (rssi_in),
      .busy         (busy),
      .rssiA        (rssiA),
      .rssiB        (rssiB),
      .rssiC        (rssiC),
      .rssi_ready   (rssi_ready),
      .out_update   (out_update),
      .sample_drop  (sample_drop),
      .id_err       (id_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of inputs, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic v, input logic [1:0] id, input logic [W-1:0] d);
      sample_valid = v;
      anchor_id    = id;
      rssi_in      = d;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      tests++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic feedWindow(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'd0, va);
         applyStimulus(1'b1, 2'd1, vb);
         applyStimulus(1'b1, 2'd2, vc);
      end
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'd0, '0);
   endtask

   initial begin
      tests        = 0;
      failures     = 0;
      rst_n        = 1'b0;
      flush        = 1'b0;
      sample_valid = 1'b0;
      anchor_id    = 2'd0;
      rssi_in      = '0;
      busy         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("reset_rssiA", rssiA, 20'h00000);
      checkOutput("reset_ready", 20'(rssi_ready), 20'd0);
      checkOutput("reset_update", 20'(out_update), 20'd0);

      // Basic average: two -70.0 and two -72.0 per anchor
      for (int i = 0; i < 4; i++) begin
         for (int a = 0; a < 3; a++)
            applyStimulus(1'b1, 2'(a), (i < 2) ? 20'hBA000 : 20'hB8000);
      end
      idle();
      checkOutput("basic_not_yet", rssiA, 20'h00000);
      checkOutput("basic_upd_early", 20'(out_update), 20'd0);
      idle();
      checkOutput("basic_rssiA", rssiA, 20'hB9000);
      checkOutput("basic_rssiB", rssiB, 20'hB9000);
      checkOutput("basic_rssiC", rssiC, 20'hB9000);
      checkOutput("basic_ready", 20'(rssi_ready), 20'd1);
      checkOutput("basic_update", 20'(out_update), 20'd1);
      idle();
      checkOutput("basic_update_end", 20'(out_update), 20'd0);

      // Rounding toward -inf
      applyStimulus(1'b1, 2'd0, 20'hFFFFF);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 20'h00000);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'd1, 20'h00000);
         applyStimulus(1'b1, 2'd2, 20'h00000);
      end
      idle();
      idle();
      checkOutput("round_rssiA", rssiA, 20'hFFFFF);
      checkOutput("round_rssiB", rssiB, 20'h00000);
      checkOutput("round_rssiC", rssiC, 20'h00000);

      // Busy hold
      busy = 1'b1;
      feedWindow(20'hBA000, 20'hBA000, 20'hBA000);
      repeat (3) idle();
      checkOutput("busy_hold_rssiA", rssiA, 20'hFFFFF);
      checkOutput("busy_hold_update", 20'(out_update), 20'd0);
      busy = 1'b0;
      idle();
      checkOutput("busy_rel_rssiA", rssiA, 20'hBA000);
      checkOutput("busy_rel_rssiB", rssiB, 20'hBA000);
      checkOutput("busy_rel_update", 20'(out_update), 20'd1);
      idle();
      checkOutput("busy_rel_update_end", 20'(out_update), 20'd0);

      // Drops and illegal ID
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 20'hB8000);
      checkOutput("no_drop_yet", 20'(sample_drop), 20'd0);
      applyStimulus(1'b1, 2'd0, 20'h00000);
      checkOutput("drop_fifth", 20'(sample_drop), 20'd1);
      applyStimulus(1'b1, 2'd3, 20'h12345);
      checkOutput("idErr_pulse", 20'(id_err), 20'd1);
      checkOutput("idErr_no_drop", 20'(sample_drop), 20'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'd1, 20'hBA000);
         applyStimulus(1'b1, 2'd2, 20'hBA000);
      end
      checkOutput("idErr_end", 20'(id_err), 20'd0);
      applyStimulus(1'b1, 2'd1, 20'h12345);
      checkOutput("drop_divide", 20'(sample_drop), 20'd1);
      idle();
      checkOutput("drop_rssiA", rssiA, 20'hB8000);
      checkOutput("drop_rssiB", rssiB, 20'hBA000);
      checkOutput("drop_update", 20'(out_update), 20'd1);

      // Overrun: two windows while busy
      busy = 1'b1;
      feedWindow(20'hBA000, 20'hBA000, 20'hBA000);
      idle();
      checkOutput("overrun_first", 20'(overrun), 20'd0);
      feedWindow(20'hC4000, 20'hC4000, 20'hC4000);
      idle();
      checkOutput("overrun_second", 20'(overrun), 20'd1);
      checkOutput("overrun_frozen", rssiA, 20'hB8000);
      idle();
      checkOutput("overrun_end", 20'(overrun), 20'd0);
      busy = 1'b0;
      idle();
      checkOutput("overrun_rssiA", rssiA, 20'hC4000);
      checkOutput("overrun_rssiC", rssiC, 20'hC4000);
      checkOutput("overrun_update", 20'(out_update), 20'd1);

      // Flush mid-window discards partial sums
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 2'd0, 20'h10000);
         applyStimulus(1'b1, 2'd1, 20'h10000);
         applyStimulus(1'b1, 2'd2, 20'h10000);
      end
      flush = 1'b1;
      applyStimulus(1'b1, 2'd0, 20'h10000);
      flush = 1'b0;
      checkOutput("flush_no_drop", 20'(sample_drop), 20'd0);
      checkOutput("flush_keeps_out", rssiA, 20'hC4000);
      checkOutput("flush_keeps_ready", 20'(rssi_ready), 20'd1);
      feedWindow(20'hB8000, 20'hB8000, 20'hB8000);
      idle();
      idle();
      checkOutput("flush_rssiA", rssiA, 20'hB8000);
      checkOutput("flush_rssiB", rssiB, 20'hB8000);
      checkOutput("flush_rssiC", rssiC, 20'hB8000);

      // Asynchronous reset in the DIVIDE cycle
      feedWindow(20'hBA000, 20'hBA000, 20'hBA000);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_rssiA", rssiA, 20'h00000);
      checkOutput("areset_rssiB", rssiB, 20'h00000);
      checkOutput("areset_ready", 20'(rssi_ready), 20'd0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle();
      idle();
      checkOutput("areset_no_update", 20'(out_update), 20'd0);
      checkOutput("areset_stays_zero", rssiC, 20'h00000);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/rssi_frontend.md
Name: rssi_frontend

Overview:
Upstream stage of the trilateration solver. Collects raw per-anchor RSSI samples from the receiver interface and averages 2^LOG2_N samples per anchor into one window. It then presents stable rssiA/rssiB/rssiC words to the solver, updating them only while the solver's busy is low, so operands never change mid-computation.

Parameters:
LOG2_N, 2, log2 of the number of samples averaged per anchor per window (N = 4).
W, 20, RSSI word width: signed two's-complement dBm, 8 integer + 12 fractional bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
flush  in  1  synchronous: discard the current window and the pending set
sample_valid  in  1  rssi_in/anchor_id valid this cycle
anchor_id  in  2  0=A, 1=B, 2=C, 3=illegal
rssi_in  in  W  raw signed RSSI sample
busy  in  1  solver busy; outputs may only change while low
rssiA  out  W  averaged RSSI, anchor A (registered)
rssiB  out  W  averaged RSSI, anchor B (registered)
rssiC  out  W  averaged RSSI, anchor C (registered)
rssi_ready  out  1  sticky high once outputs have been loaded at least once
out_update  out  1  1-cycle pulse in the cycle after rssiA/B/C were reloaded
sample_drop  out  1  1-cycle pulse: a valid sample was discarded
id_err  out  1  1-cycle pulse: sample_valid with anchor_id==3
overrun  out  1  1-cycle pulse: the pending set was overwritten before transfer

Behaviour:
- Reset (rst_n low, async): all outputs 0, accumulators and counters 0, pending flag 0, FSM in COLLECT.
- Accumulators: three signed accumulators of W+LOG2_N bits; inputs are sign-extended; no saturation is needed.
- Counters: three per-anchor counters of LOG2_N+1 bits.
- FSM states are COLLECT and DIVIDE.
- COLLECT, valid sample, id 0..2, anchor count < N: add the sample to that anchor's accumulator and increment its count.
- COLLECT, valid sample, anchor count already == N: drop the sample; sample_drop pulses the next cycle.
- anchor_id==3 in any state: sample ignored; id_err pulses. sample_drop does not pulse.
- COLLECT -> DIVIDE at the edge where all three counts equal N (the last sample's own edge counts).
- DIVIDE lasts exactly 1 cycle:
  - pending_X = acc_X >>> LOG2_N (arithmetic shift, floor toward -inf, low W bits).
  - Accumulators and counts clear; pend flag sets; return to COLLECT.
- Valid samples during DIVIDE are dropped and sample_drop pulses.
- If pend flag is already set when DIVIDE writes, and no transfer happens that cycle: pending is overwritten and overrun pulses.
- Transfer: on any edge with pend flag==1 and busy==0, rssiA/B/C <= pending, pend flag clears, rssi_ready sets, and out_update is high the following cycle.
- Transfer and DIVIDE on the same edge:
  - Outputs take the old pending values.
  - New pending loads and pend flag stays 1.
  - No overrun.
- Latency with busy low: last sample at edge k, DIVIDE at edge k+1, outputs valid after edge k+2, out_update high in cycle k+2..k+3.
- While busy is high, outputs are frozen regardless of internal activity.
- flush: clears accumulators, counts and pend flag, and forces COLLECT. It does not alter rssiA/B/C or rssi_ready. A sample in the same cycle is discarded without a sample_drop pulse.
- flush has priority over sample accumulation, DIVIDE and transfer.

Decomposition:
- Shared package:
  - W and the fixed-point format constants (INT_BITS=8, FRAC_BITS=12).
  - Anchor ID encodings ANCH_A/B/C/ILLEGAL.
  - FSM state encodings COLLECT/DIVIDE.
- One natural sub-module, rssi_acc: a single accumulator + counter + full flag + shift-average. Instantiate it three times.
- Top level holds the FSM, pending registers and transfer logic.

Test Plan:
- Basic average, busy=0, LOG2_N=2:
  - Stimulus: per anchor, two samples of 20'hBA000 (-70.0) and two of 20'hB8000 (-72.0), interleaved A,B,C.
  - Response: rssiA/B/C=20'hB9000 (-71.0) two edges after the last sample; one out_update pulse; rssi_ready=1.
- Rounding:
  - Stimulus: anchor A gets samples 20'hFFFFF,0,0,0; B and C get 4x 20'h00000.
  - Response: rssiA=20'hFFFFF (floor of -0.25 LSB), rssiB=rssiC=0.
- Busy hold:
  - Stimulus: busy=1; complete a window of 4x 20'hBA000 per anchor.
  - Response: outputs stay at their prior value. Release busy: outputs become 20'hBA000 on the next edge and out_update pulses once.
- Drops and illegal ID:
  - 5th A sample while the B/C windows are incomplete -> sample_drop pulse, A average unaffected.
  - anchor_id=3 -> id_err pulse only.
  - Sample in the DIVIDE cycle -> sample_drop.
- Overrun:
  - Stimulus: busy=1; two full windows (all -70.0, then all -60.0 = 20'hC4000).
  - Response: overrun pulses at the 2nd DIVIDE. After busy falls, outputs = 20'hC4000.
- Reset and flush:
  - flush mid-window (2 of 4 samples given), then 4 fresh samples of 20'hB8000 per anchor -> outputs 20'hB8000.
  - rst_n low mid-DIVIDE -> all outputs 0 immediately (async), rssi_ready=0.
